// File: rtl/instr_window_builder.sv
// Previous/current/next window over the committed-instruction stream.
// The current slot is emitted once its successor commits, or when a flush drains the window.
module instr_window_builder #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] iaddr_i,
  input  logic [ILEN-1:0] inst_data_i,
  input  logic            compressed_i,
  input  logic            exception_i,
  input  logic            interrupt_i,
  input  logic            eret_i,
  input  logic            flush_i,
  output logic            window_valid_o,
  output logic            pc_valid_o,
  output logic            cc_valid_o,
  output logic            nc_valid_o,
  output logic [XLEN-1:0] pc_iaddr_o,
  output logic [XLEN-1:0] cc_iaddr_o,
  output logic [XLEN-1:0] nc_iaddr_o,
  output logic [ILEN-1:0] cc_inst_data_o,
  output logic            cc_compressed_o,
  output logic            cc_exception_o,
  output logic            cc_interrupt_o,
  output logic            cc_eret_o,
  output logic            busy_o,
  output logic            drop_o
);

  // state | meaning
  // IDLE  | next slot empty, waiting for the first commit
  // RUN   | window filling/shifting on every commit
  // DRAIN | bubble shift: last instruction becomes cc with no successor
  // CLEAR | all slots invalidated, inputs still refused
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, CLEAR} state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic            advance;
  logic [ILEN-1:0] n_inst;
  logic [3:0]      n_flags;

  // busy_o is a registered copy of "state is DRAIN or CLEAR"
  assign accept  = valid_i && !busy_o;
  assign advance = accept || (state == DRAIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = flush_i ? DRAIN : RUN;
      RUN:     if (flush_i) state_nxt = DRAIN;
      DRAIN:   state_nxt = CLEAR;
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      window_valid_o  <= 1'b0;
      pc_valid_o      <= 1'b0;
      cc_valid_o      <= 1'b0;
      nc_valid_o      <= 1'b0;
      pc_iaddr_o      <= '0;
      cc_iaddr_o      <= '0;
      nc_iaddr_o      <= '0;
      cc_inst_data_o  <= '0;
      cc_compressed_o <= 1'b0;
      cc_exception_o  <= 1'b0;
      cc_interrupt_o  <= 1'b0;
      cc_eret_o       <= 1'b0;
      n_inst          <= '0;
      n_flags         <= '0;
      busy_o          <= 1'b0;
      drop_o          <= 1'b0;
    end else begin
      state          <= state_nxt;
      busy_o         <= (state_nxt == DRAIN) || (state_nxt == CLEAR);
      drop_o         <= valid_i && busy_o;
      window_valid_o <= 1'b0;
      if (advance) begin
        pc_valid_o     <= cc_valid_o;
        pc_iaddr_o     <= cc_iaddr_o;
        cc_valid_o     <= nc_valid_o;
        cc_iaddr_o     <= nc_iaddr_o;
        cc_inst_data_o <= n_inst;
        {cc_compressed_o, cc_exception_o, cc_interrupt_o, cc_eret_o} <= n_flags;
        window_valid_o <= nc_valid_o;
        nc_valid_o     <= accept;
        if (accept) begin
          nc_iaddr_o <= iaddr_i;
          n_inst     <= inst_data_i;
          n_flags    <= {compressed_i, exception_i, interrupt_i, eret_i};
        end
      end
      // Data is left in place; only the valid bits are dropped.
      if (state == CLEAR) begin
        pc_valid_o <= 1'b0;
        cc_valid_o <= 1'b0;
        nc_valid_o <= 1'b0;
      end
    end
  end

endmodule
